// File: rtl/clock_core_cfg.sv
// Parametrised time-of-day datapath: sub/sec/min/hour counters with run/stop,
// per-field manual setting with edge-detected buttons and auto-repeat, 12/24h
// display decode and a day-rollover pulse.
module clock_core_cfg #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int TICK_HZ      = 100,
  parameter int HOUR_START   = 12,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_run,
  input  logic [1:0]                 i_sel,
  input  logic                       btn_up,
  input  logic                       btn_down,
  input  logic                       i_mode12,
  output logic [$clog2(TICK_HZ)-1:0] o_sub,
  output logic [5:0]                 o_sec,
  output logic [5:0]                 o_min,
  output logic [4:0]                 o_hour,
  output logic [4:0]                 o_hour_disp,
  output logic                       o_pm,
  output logic                       o_day_tick
);

  localparam int DIV  = CLK_HZ / TICK_HZ;
  localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW   = $clog2(TICK_HZ);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_SEC  = 2'd1;
  localparam logic [1:0] SEL_MIN  = 2'd2;
  localparam logic [1:0] SEL_HOUR = 2'd3;

  // Repeat sequencer: waiting for the first repeat, then stepping at the rate.
  typedef enum logic [1:0] {
    REP_IDLE  = 2'd0,
    REP_DELAY = 2'd1,
    REP_RATE  = 2'd2
  } rep_state_t;

  logic [PW-1:0] presc;
  logic          base_tick;
  logic          btn_up_q;
  logic          btn_down_q;
  logic [1:0]    sel_q;

  rep_state_t    rep_state, rep_state_nx;
  logic [RW-1:0] rep_cnt, rep_cnt_nx;
  logic          rep_up, rep_up_nx;
  logic          edge_up, edge_dn, hold_lost;
  logic          step, step_up;

  logic [SW-1:0] sub_nx;
  logic [5:0]    sec_nx, min_nx;
  logic [4:0]    hour_nx;
  logic [5:0]    hour_tmp;
  logic          day_nx;
  logic          c_sec, c_min, c_hour;

  // One step of a wrapping field; down from 0 goes to top.
  function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic up,
                                           input logic [5:0] top);
    logic [5:0] r;
    if (up) r = (v == top) ? 6'd0 : v + 6'd1;
    else    r = (v == 6'd0) ? top : v - 6'd1;
    return r;
  endfunction

  assign base_tick = (presc == PW'(DIV - 1));

  // Free-running prescaler producing the base tick; ignores i_run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            presc <= '0;
    else if (base_tick) presc <= '0;
    else                presc <= presc + PW'(1);
  end

  // Previous button levels and field select for edge/change detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_up_q   <= 1'b0;
      btn_down_q <= 1'b0;
      sel_q      <= SEL_NONE;
    end else begin
      btn_up_q   <= btn_up;
      btn_down_q <= btn_down;
      sel_q      <= i_sel;
    end
  end

  assign edge_up   = (i_sel != SEL_NONE) && btn_up && !btn_up_q && !btn_down;
  assign edge_dn   = (i_sel != SEL_NONE) && btn_down && !btn_down_q && !btn_up;
  assign hold_lost = (i_sel == SEL_NONE) || (i_sel != sel_q) || (btn_up && btn_down) ||
                     (rep_up ? !btn_up : !btn_down);

  // Repeat state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_state <= REP_IDLE;
      rep_cnt   <= '0;
      rep_up    <= 1'b0;
    end else begin
      rep_state <= rep_state_nx;
      rep_cnt   <= rep_cnt_nx;
      rep_up    <= rep_up_nx;
    end
  end

  // Step decision: a fresh edge always steps and re-arms; a held button steps
  // after the delay and then at the repeat rate, counted in base ticks.
  always_comb begin
    rep_state_nx = rep_state;
    rep_cnt_nx   = rep_cnt;
    rep_up_nx    = rep_up;
    step         = 1'b0;
    step_up      = 1'b0;
    if (edge_up || edge_dn) begin
      step         = 1'b1;
      step_up      = edge_up;
      rep_state_nx = REP_DELAY;
      rep_cnt_nx   = '0;
      rep_up_nx    = edge_up;
    end else begin
      case (rep_state)
        REP_DELAY, REP_RATE: begin
          if (hold_lost) begin
            rep_state_nx = REP_IDLE;
            rep_cnt_nx   = '0;
          end else if (base_tick) begin
            if (rep_cnt == ((rep_state == REP_DELAY) ? RW'(REPEAT_DELAY - 1)
                                                     : RW'(REPEAT_RATE - 1))) begin
              step         = 1'b1;
              step_up      = rep_up;
              rep_state_nx = REP_RATE;
              rep_cnt_nx   = '0;
            end else begin
              rep_cnt_nx = rep_cnt + RW'(1);
            end
          end
        end
        default: begin
          rep_state_nx = REP_IDLE;
          rep_cnt_nx   = '0;
        end
      endcase
    end
  end

  // Counter chain: carries ripple within one cycle; the selected field takes
  // only manual steps and breaks the chain above it.
  always_comb begin
    sub_nx   = o_sub;
    sec_nx   = o_sec;
    min_nx   = o_min;
    hour_nx  = o_hour;
    hour_tmp = 6'd0;
    day_nx   = 1'b0;
    c_sec    = 1'b0;
    c_min    = 1'b0;
    c_hour   = 1'b0;

    if (base_tick && i_run) begin
      if (o_sub == SW'(TICK_HZ - 1)) begin
        sub_nx = '0;
        c_sec  = 1'b1;
      end else begin
        sub_nx = o_sub + SW'(1);
      end
    end

    if (i_sel == SEL_SEC) begin
      if (step) begin
        sec_nx = wrap_step(o_sec, step_up, 6'd59);
        sub_nx = '0;
      end
    end else if (c_sec) begin
      if (o_sec == 6'd59) begin
        sec_nx = 6'd0;
        c_min  = 1'b1;
      end else begin
        sec_nx = o_sec + 6'd1;
      end
    end

    if (i_sel == SEL_MIN) begin
      if (step) min_nx = wrap_step(o_min, step_up, 6'd59);
    end else if (c_min) begin
      if (o_min == 6'd59) begin
        min_nx = 6'd0;
        c_hour = 1'b1;
      end else begin
        min_nx = o_min + 6'd1;
      end
    end

    if (i_sel == SEL_HOUR) begin
      if (step) begin
        hour_tmp = wrap_step({1'b0, o_hour}, step_up, 6'd23);
        hour_nx  = hour_tmp[4:0];
      end
    end else if (c_hour) begin
      if (o_hour == 5'd23) begin
        hour_nx = 5'd0;
        day_nx  = 1'b1;
      end else begin
        hour_nx = o_hour + 5'd1;
      end
    end
  end

  // Time-of-day registers and the day-rollover pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_sub      <= '0;
      o_sec      <= 6'd0;
      o_min      <= 6'd0;
      o_hour     <= 5'(HOUR_START);
      o_day_tick <= 1'b0;
    end else begin
      o_sub      <= sub_nx;
      o_sec      <= sec_nx;
      o_min      <= min_nx;
      o_hour     <= hour_nx;
      o_day_tick <= day_nx;
    end
  end

  // Display decode from the registered 24h hour.
  always_comb begin
    o_pm        = (o_hour >= 5'd12);
    o_hour_disp = o_hour;
    if (i_mode12) begin
      if (o_hour == 5'd0)       o_hour_disp = 5'd12;
      else if (o_hour > 5'd12)  o_hour_disp = o_hour - 5'd12;
    end
  end

endmodule

// File: doc/clock_core_cfg.md
Name: clock_core_cfg

Overview:
Parametrised time-of-day datapath: sub-second, seconds, minutes and hours counters with run/stop control and per-field manual setting. Setting uses edge-detected up/down buttons with auto-repeat on hold, and the block provides 12/24-hour display decode and a day-rollover pulse. It sits between the debounced button/mode controller and the display mux. It supersedes the fixed-rate watch datapath.

Parameters:
CLK_HZ, 100_000_000, input clock frequency in Hz.
TICK_HZ, 100, sub-second rate; sub field counts 0..TICK_HZ-1; CLK_HZ must be an integer multiple of TICK_HZ.
HOUR_START, 12, hour value loaded at reset, 0..23.
REPEAT_DELAY, 50, base ticks of continuous hold before the first auto-repeat step.
REPEAT_RATE, 10, base ticks between subsequent auto-repeat steps.

Ports:
clk  in  1  clock.
rst  in  1  reset, asynchronous, active-high.
i_run  in  1  1 = time advances; 0 = sub/sec/min/hour frozen except for manual steps.
i_sel  in  2  field select: 0 none, 1 sec, 2 min, 3 hour.
btn_up  in  1  increment request, level, already debounced.
btn_down  in  1  decrement request, level, already debounced.
i_mode12  in  1  1 = 12-hour display decode.
o_sub  out  $clog2(TICK_HZ)  sub-second count.
o_sec  out  6  seconds 0..59.
o_min  out  6  minutes 0..59.
o_hour  out  5  hours 0..23, internal 24h value.
o_hour_disp  out  5  display hour: 1..12 when i_mode12=1, else equals o_hour.
o_pm  out  1  1 when o_hour >= 12, independent of i_mode12.
o_day_tick  out  1  one-cycle pulse on the automatic 23:59:59.last -> 00:00:00.0 rollover.

Behaviour:
- Reset values: prescaler 0, o_sub 0, o_sec 0, o_min 0, o_hour HOUR_START, o_day_tick 0. Button history, repeat counter and repeat-armed flag all clear.
- Prescaler is free-running, unaffected by i_run. It counts 0..CLK_HZ/TICK_HZ-1 and asserts an internal base tick for one cycle at the terminal count.
- Counting: base tick with i_run=1 increments sub. Carry ripple is combinational, so every field updates on the same clk edge:
  - sub wraps TICK_HZ-1 -> 0 and carries to sec.
  - sec wraps 59 -> 0 and carries to min.
  - min wraps 59 -> 0 and carries to hour.
  - hour wraps 23 -> 0 and asserts o_day_tick on that edge, for one cycle.
- Button edges: btn_up and btn_down are registered once. Rising edge = current 1 and previous 0.
- Manual step (i_sel != 0):
  - A rising edge on exactly one button, with the other button low, steps the selected field by ±1.
  - Wrap rules per field: sec/min 59 <-> 0, hour 23 <-> 0.
  - No carry or borrow propagates to neighbouring fields. Manual wraps never assert o_day_tick.
  - A manual step on sec also clears sub to 0.
- Auto-repeat:
  - While the same single button stays high, a repeat counter counts base ticks.
  - The first repeat step comes REPEAT_DELAY ticks after the edge; further steps come every REPEAT_RATE ticks.
  - The repeat state clears on button release, on both buttons high, or on any change of i_sel.
- Selected field while setting: it ignores carries from below and generates no carry upward. Unselected fields keep counting and carrying normally, with the chain broken at the selected field. A manual step and an incoming carry in the same cycle: the manual step wins and the carry is dropped.
- Both buttons high: no step, repeat held cleared. An edge on one button while the other is high is ignored.
- i_sel = 0: buttons ignored, repeat state cleared.
- Display decode (combinational from registered o_hour):
  - i_mode12=1: hour 0 -> 12, 1..11 -> same, 12 -> 12, 13..23 -> hour-12.
  - i_mode12=0: o_hour_disp = o_hour.
- Reset asserted mid-operation clears everything immediately, including a pending repeat and o_day_tick.

Test Plan:
1. Assert then release rst -> 12:00:00.00, o_pm=1, o_hour_disp=12 with i_mode12=1, o_day_tick=0.
2. CLK_HZ=1000, TICK_HZ=100, set 23:59:59 and run until sub=99; next base tick -> all fields 0 on one edge, o_day_tick high exactly 1 cycle.
3. i_sel=2, min=59, single btn_up pulse -> min=0, hour unchanged. i_sel=1, sec=0, btn_down pulse -> sec=59, sub=0, min unchanged.
4. i_sel=3, hour=10, hold btn_down for REPEAT_DELAY+3*REPEAT_RATE base ticks -> exactly 5 decrements (edge + 4 repeats), hour=5. Release -> no further steps.
5. btn_up and btn_down both high -> no field change. i_run=0 for 500 ticks -> sub/sec frozen while btn_up on i_sel=2 still steps min.
6. i_mode12=1, hour forced to 0, 11, 12, 13 -> o_hour_disp 12, 11, 12, 1 and o_pm 0, 0, 1, 1. i_mode12=0 -> o_hour_disp 0, 11, 12, 13.
